biquad_cascade_seq: RTL

Cascade of SECTIONS direct-form-II biquad sections in signed fixed point Q(P.F). All sections share one time-multiplexed multiplier and adder. The block sits in the signal path where a single biquad sat before, with a valid/ready sample handshake, run-time coefficient loading, and saturating arithmetic with a sticky overflow flag.

---
 rtl/biquad_cascade_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/biquad_cascade_seq.sv
// Cascade of SECTIONS direct-form-II biquads sharing one saturating multiplier and adder.
// Each section takes six cycles; the final section output is presented on yk with a one-cycle pulse.
module biquad_cascade_seq #(
  parameter int unsigned P        = 8,
  parameter int unsigned F        = 14,
  parameter int unsigned WIDTH    = 1 + P + F,
  parameter int unsigned SECTIONS = 4,
  parameter int unsigned SW       = (SECTIONS > 1) ? $clog2(SECTIONS) : 1
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] uk,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] yk,
  input  logic                    coef_we,
  input  logic [SW-1:0]           coef_sec,
  input  logic [2:0]              coef_sel,
  input  logic signed [WIDTH-1:0] coef_data,
  input  logic                    clear_state,
  output logic                    sat_flag
);
  localparam logic signed [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] One    = {{(WIDTH-1-F){1'b0}}, 1'b1, {F{1'b0}}};
  localparam int unsigned IdxA1 = 0;
  localparam int unsigned IdxA2 = 1;
  localparam int unsigned IdxB0 = 2;
  localparam int unsigned IdxB1 = 3;
  localparam int unsigned IdxB2 = 4;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              step_q;
  logic [SW-1:0]           sec_q;
  logic signed [WIDTH-1:0] x_q, acc_q, w_q, yk_q;
  logic signed [WIDTH-1:0] f1_q [SECTIONS];
  logic signed [WIDTH-1:0] f2_q [SECTIONS];
  logic signed [WIDTH-1:0] coef_q [SECTIONS][5];
  logic                    pend_q, sat_q;

  logic                      last_step, coef_ok;
  logic signed [WIDTH-1:0]   mc, mv, addend, m, res;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH:0]            hi;
  logic signed [WIDTH:0]     sum;
  logic                      m_ovf, s_ovf;

  assign last_step = (step_q == 3'd5) && (sec_q == SW'(SECTIONS - 1));
  assign coef_ok   = coef_we && (state_q == StIdle) && enable && (coef_sel <= 3'd4) &&
                     (32'(coef_sec) < SECTIONS);

  // FSM: state register
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StBusy;
      StBusy:  if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs; a completed result waits in pend_q while frozen
  always_comb begin
    in_ready  = (state_q == StIdle) && enable;
    out_valid = pend_q && enable;
  end

  assign yk       = yk_q;
  assign sat_flag = sat_q;

  // Shared multiply-accumulate operand selection per step
  always_comb begin
    mc     = '0;
    mv     = '0;
    addend = '0;
    case (step_q)
      3'd0: begin mc = coef_q[sec_q][IdxA1]; mv = f1_q[sec_q]; addend = x_q;   end
      3'd1: begin mc = coef_q[sec_q][IdxA2]; mv = f2_q[sec_q]; addend = acc_q; end
      3'd2: begin mc = coef_q[sec_q][IdxB0]; mv = w_q;                         end
      3'd3: begin mc = coef_q[sec_q][IdxB1]; mv = f1_q[sec_q]; addend = acc_q; end
      3'd4: begin mc = coef_q[sec_q][IdxB2]; mv = f2_q[sec_q]; addend = acc_q; end
      default: ;
    endcase
  end

  always_comb begin
    prod    = (2*WIDTH)'(mc) * (2*WIDTH)'(mv);
    prod_sh = prod >>> F;
    hi      = prod_sh[2*WIDTH-1:WIDTH-1];
    m_ovf   = !((&hi) || !(|hi));
    m       = m_ovf ? (prod_sh[2*WIDTH-1] ? MinVal : MaxVal) : prod_sh[WIDTH-1:0];
    sum     = {addend[WIDTH-1], addend} + {m[WIDTH-1], m};
    s_ovf   = sum[WIDTH] ^ sum[WIDTH-1];
    res     = s_ovf ? (sum[WIDTH] ? MinVal : MaxVal) : sum[WIDTH-1:0];
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      step_q <= '0;
      sec_q  <= '0;
      x_q    <= '0;
      acc_q  <= '0;
      w_q    <= '0;
      yk_q   <= '0;
      pend_q <= 1'b0;
      sat_q  <= 1'b0;
      for (int s = 0; s < SECTIONS; s++) begin
        f1_q[s] <= '0;
        f2_q[s] <= '0;
        for (int k = 0; k < 5; k++) coef_q[s][k] <= (k == IdxB0) ? One : '0;
      end
    end else if (enable) begin
      pend_q <= 1'b0;
      if (state_q == StIdle) begin
        if (coef_ok) coef_q[coef_sec][coef_sel] <= coef_data;
        if (clear_state) begin
          for (int s = 0; s < SECTIONS; s++) begin
            f1_q[s] <= '0;
            f2_q[s] <= '0;
          end
        end
        if (in_valid) begin
          x_q    <= uk;
          step_q <= '0;
          sec_q  <= '0;
        end
      end else if (step_q != 3'd5) begin
        sat_q <= sat_q | m_ovf | s_ovf;
        if (step_q == 3'd1) w_q <= res;
        else acc_q <= res;
        step_q <= step_q + 3'd1;
      end else begin
        f2_q[sec_q] <= f1_q[sec_q];
        f1_q[sec_q] <= w_q;
        x_q         <= acc_q;
        step_q      <= '0;
        if (last_step) begin
          yk_q   <= acc_q;
          pend_q <= 1'b1;
          sec_q  <= '0;
        end else begin
          sec_q <= sec_q + SW'(1);
        end
      end
    end
  end

endmodule
